// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl - way-replacement and line-refill controller for one set-associative cache lookup at a time.
// Hits update PLRU in place; misses pick a victim, write it back if dirty, refill it beat by beat, then report done.
module cache_miss_ctrl #(
  parameter int ASSOC_NUM  = 4,
  parameter int INDEX_W    = 7,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          lookup_valid,
  output logic                          lookup_ready,
  input  logic [INDEX_W-1:0]            lookup_index,
  input  logic [ASSOC_NUM-1:0]          hit_way,
  input  logic [ASSOC_NUM-1:0]          set_valid,
  input  logic [ASSOC_NUM-1:0]          set_dirty,
  input  logic [$clog2(ASSOC_NUM)-1:0]  plru_lru,
  output logic [ASSOC_NUM-1:0]          plru_access,
  output logic                          plru_update,
  output logic                          wb_req,
  output logic [$clog2(ASSOC_NUM)-1:0]  wb_way,
  input  logic                          wb_ack,
  output logic                          rd_req,
  output logic [INDEX_W-1:0]            rd_index,
  input  logic                          rd_ack,
  input  logic                          rd_beat_valid,
  output logic                          fill_we,
  output logic [$clog2(ASSOC_NUM)-1:0]  fill_way,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word,
  output logic                          miss_done
);

  localparam int WAY_W = $clog2(ASSOC_NUM);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_REQ  = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic [WAY_W-1:0] pick_way;

  // Lowest-indexed invalid way wins; only a fully valid set falls back to PLRU.
  always_comb begin
    pick_way = plru_lru;
    for (int i = ASSOC_NUM - 1; i >= 0; i--) begin
      if (!set_valid[i]) pick_way = WAY_W'(i);
    end
  end

  assign accept = lookup_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      index_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    index_d     = index_q;
    cnt_d       = cnt_q;
    plru_access = '0;
    plru_update = 1'b0;
    fill_we     = 1'b0;
    miss_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (|hit_way) begin
            plru_access = hit_way;
            plru_update = 1'b1;
          end else begin
            index_d  = lookup_index;
            victim_d = pick_way;
            if (set_valid[pick_way] && set_dirty[pick_way]) state_d = S_WB;
            else                                            state_d = S_REQ;
          end
        end
      end
      S_WB: begin
        if (wb_ack) state_d = S_REQ;
      end
      S_REQ: begin
        if (rd_ack) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (rd_beat_valid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_DONE: begin
        miss_done   = 1'b1;
        plru_access = ASSOC_NUM'(1) << victim_q;
        plru_update = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requests decode straight from state so an asynchronous reset drops them at once.
  assign lookup_ready = (state_q == S_IDLE);
  assign wb_req       = (state_q == S_WB);
  assign rd_req       = (state_q == S_REQ);
  assign wb_way       = victim_q;
  assign fill_way     = victim_q;
  assign rd_index     = index_q;
  assign fill_word    = cnt_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - directed self-checking bench for cache_miss_ctrl.
module tb_cache_miss_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       lookup_valid;
  logic       lookup_ready;
  logic [6:0] lookup_index;
  logic [3:0] hit_way;
  logic [3:0] set_valid;
  logic [3:0] set_dirty;
  logic [1:0] plru_lru;
  logic [3:0] plru_access;
  logic       plru_update;
  logic       wb_req;
  logic [1:0] wb_way;
  logic       wb_ack;
  logic       rd_req;
  logic [6:0] rd_index;
  logic       rd_ack;
  logic       rd_beat_valid;
  logic       fill_we;
  logic [1:0] fill_way;
  logic [2:0] fill_word;
  logic       miss_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl #(.ASSOC_NUM(4), .INDEX_W(7), .LINE_WORDS(8)) dut (
    .clk(clk), .resetn(resetn),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_index(lookup_index),
    .hit_way(hit_way), .set_valid(set_valid), .set_dirty(set_dirty), .plru_lru(plru_lru),
    .plru_access(plru_access), .plru_update(plru_update),
    .wb_req(wb_req), .wb_way(wb_way), .wb_ack(wb_ack),
    .rd_req(rd_req), .rd_index(rd_index), .rd_ack(rd_ack), .rd_beat_valid(rd_beat_valid),
    .fill_we(fill_we), .fill_way(fill_way), .fill_word(fill_word), .miss_done(miss_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; lookup_valid = 0; lookup_index = 0; hit_way = 0; set_valid = 0;
    set_dirty = 0; plru_lru = 0; wb_ack = 0; rd_ack = 0; rd_beat_valid = 0;
    tick(); tick();
    tests++; if (lookup_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", lookup_ready); end
    tests++; if ({wb_req, rd_req, fill_we, miss_done, plru_update} !== 5'b0) begin
      fails++; $display("FAIL reset_outs got=%b exp=00000", {wb_req, rd_req, fill_we, miss_done, plru_update}); end
    tests++; if (fill_word !== 3'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", fill_word); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_hit();
    lookup_valid = 1; hit_way = 4'b0100; set_valid = 4'hF; #1;
    tests++; if (plru_access !== 4'b0100) begin fails++; $display("FAIL hit_access got=%b exp=0100", plru_access); end
    tests++; if (plru_update !== 1'b1) begin fails++; $display("FAIL hit_update got=%b exp=1", plru_update); end
    tick(); lookup_valid = 0; hit_way = 0; #1;
    tests++; if (lookup_ready !== 1'b1 || rd_req !== 1'b0 || wb_req !== 1'b0) begin
      fails++; $display("FAIL hit_stay_idle ready=%b rd=%b wb=%b exp=1,0,0", lookup_ready, rd_req, wb_req); end
  endtask

  task automatic test_clean_miss();
    lookup_valid = 1; hit_way = 0; set_valid = 4'b1011; set_dirty = 4'b0100; plru_lru = 0;
    lookup_index = 7'h15; #1;
    tests++; if (plru_update !== 1'b0) begin fails++; $display("FAIL cm_miss_update got=%b exp=0", plru_update); end
    tick(); lookup_valid = 0; #1;
    tests++; if (wb_req !== 1'b0 || rd_req !== 1'b1) begin
      fails++; $display("FAIL cm_req wb=%b rd=%b exp=0,1", wb_req, rd_req); end
    tests++; if (rd_index !== 7'h15) begin fails++; $display("FAIL cm_index got=%h exp=15", rd_index); end
    tests++; if (lookup_ready !== 1'b0) begin fails++; $display("FAIL cm_ready got=%b exp=0", lookup_ready); end
    rd_ack = 1; tick(); rd_ack = 0;
    for (int i = 0; i < 8; i++) begin
      rd_beat_valid = 1; #1;
      tests++; if (fill_we !== 1'b1 || fill_way !== 2'd2 || fill_word !== 3'(i)) begin
        fails++; $display("FAIL cm_beat%0d we=%b way=%0d word=%0d exp=1,2,%0d", i, fill_we, fill_way, fill_word, i); end
      tick();
    end
    rd_beat_valid = 0; #1;
    tests++; if (miss_done !== 1'b1 || plru_access !== 4'b0100 || plru_update !== 1'b1) begin
      fails++; $display("FAIL cm_done done=%b acc=%b upd=%b exp=1,0100,1", miss_done, plru_access, plru_update); end
    tick();
    tests++; if (miss_done !== 1'b0 || lookup_ready !== 1'b1) begin
      fails++; $display("FAIL cm_idle done=%b ready=%b exp=0,1", miss_done, lookup_ready); end
  endtask

  task automatic test_dirty_miss();
    lookup_valid = 1; hit_way = 0; set_valid = 4'hF; set_dirty = 4'b0010; plru_lru = 2'd1;
    lookup_index = 7'h2A;
    tick(); lookup_valid = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (wb_req !== 1'b1 || wb_way !== 2'd1 || rd_req !== 1'b0) begin
        fails++; $display("FAIL dm_wb_c%0d wb=%b way=%0d rd=%b exp=1,1,0", c, wb_req, wb_way, rd_req); end
      if (c == 4) wb_ack = 1;
      tick();
    end
    wb_ack = 0; #1;
    tests++; if (rd_req !== 1'b1 || wb_req !== 1'b0 || rd_index !== 7'h2A) begin
      fails++; $display("FAIL dm_req rd=%b wb=%b idx=%h exp=1,0,2a", rd_req, wb_req, rd_index); end
    rd_ack = 1; tick(); rd_ack = 0;
    for (int i = 0; i < 8; i++) begin
      rd_beat_valid = 1; #1;
      tests++; if (fill_we !== 1'b1 || fill_way !== 2'd1 || fill_word !== 3'(i)) begin
        fails++; $display("FAIL dm_beat%0d we=%b way=%0d word=%0d exp=1,1,%0d", i, fill_we, fill_way, fill_word, i); end
      tick();
    end
    rd_beat_valid = 0; #1;
    tests++; if (miss_done !== 1'b1 || plru_access !== 4'b0010 || plru_update !== 1'b1) begin
      fails++; $display("FAIL dm_done done=%b acc=%b upd=%b exp=1,0010,1", miss_done, plru_access, plru_update); end
    tick();
  endtask

  task automatic test_beat_gaps();
    int nb;
    logic beat;
    nb = 0;
    lookup_valid = 1; hit_way = 0; set_valid = 4'b0111; set_dirty = 4'hF; plru_lru = 2'd2;
    lookup_index = 7'h03;
    tick(); lookup_valid = 0;
    rd_beat_valid = 1; #1;
    tests++; if (fill_we !== 1'b0 || rd_req !== 1'b1 || wb_req !== 1'b0) begin
      fails++; $display("FAIL gap_stray_req we=%b rd=%b wb=%b exp=0,1,0", fill_we, rd_req, wb_req); end
    tick(); rd_beat_valid = 0; rd_ack = 1; tick(); rd_ack = 0;
    lookup_valid = 1; hit_way = 4'b0001;
    for (int cyc = 0; cyc < 24; cyc++) begin
      beat = (cyc % 3 == 2);
      rd_beat_valid = beat; #1;
      tests++; if (fill_we !== beat || lookup_ready !== 1'b0 || plru_update !== 1'b0 || miss_done !== 1'b0) begin
        fails++; $display("FAIL gap_c%0d we=%b ready=%b upd=%b done=%b exp=%b,0,0,0",
                          cyc, fill_we, lookup_ready, plru_update, miss_done, beat); end
      if (beat) begin
        tests++; if (fill_word !== 3'(nb) || fill_way !== 2'd3) begin
          fails++; $display("FAIL gap_word%0d word=%0d way=%0d exp=%0d,3", nb, fill_word, fill_way, nb); end
        nb++;
      end
      tick();
    end
    rd_beat_valid = 0; #1;
    tests++; if (miss_done !== 1'b1 || plru_access !== 4'b1000 || nb != 8) begin
      fails++; $display("FAIL gap_done done=%b acc=%b beats=%0d exp=1,1000,8", miss_done, plru_access, nb); end
    lookup_valid = 0; hit_way = 0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    lookup_valid = 1; hit_way = 0; set_valid = 4'b1110; set_dirty = 4'h0; plru_lru = 2'd3;
    lookup_index = 7'h44;
    tick(); lookup_valid = 0; rd_ack = 1; tick(); rd_ack = 0;
    for (int i = 0; i < 4; i++) begin
      rd_beat_valid = 1; tick();
    end
    rd_beat_valid = 0;
    resetn = 0; #1;
    tests++; if (lookup_ready !== 1'b1 || rd_req !== 1'b0 || fill_word !== 3'd0) begin
      fails++; $display("FAIL rst_async ready=%b rd=%b word=%0d exp=1,0,0", lookup_ready, rd_req, fill_word); end
    tick(); resetn = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (miss_done !== 1'b0 || plru_update !== 1'b0 || lookup_ready !== 1'b1) begin
        fails++; $display("FAIL rst_quiet_c%0d done=%b upd=%b ready=%b exp=0,0,1", c, miss_done, plru_update, lookup_ready); end
      tick();
    end
    lookup_valid = 1; set_valid = 4'b1101;
    tick(); lookup_valid = 0; rd_ack = 1; tick(); rd_ack = 0;
    rd_beat_valid = 1; #1;
    tests++; if (fill_we !== 1'b1 || fill_word !== 3'd0 || fill_way !== 2'd1) begin
      fails++; $display("FAIL rst_restart we=%b word=%0d way=%0d exp=1,0,1", fill_we, fill_word, fill_way); end
    for (int i = 0; i < 8; i++) tick();
    rd_beat_valid = 0; #1;
    tests++; if (miss_done !== 1'b1 || plru_access !== 4'b0010) begin
      fails++; $display("FAIL rst_done done=%b acc=%b exp=1,0010", miss_done, plru_access); end
    tick();
  endtask

  task automatic test_back_to_back();
    lookup_valid = 1; hit_way = 0; set_valid = 4'hF; set_dirty = 4'h0; plru_lru = 2'd3;
    lookup_index = 7'h7F;
    tick(); lookup_valid = 0; #1;
    tests++; if (rd_req !== 1'b1 || wb_req !== 1'b0) begin
      fails++; $display("FAIL b2b_req rd=%b wb=%b exp=1,0", rd_req, wb_req); end
    rd_ack = 1; tick(); rd_ack = 0;
    rd_beat_valid = 1;
    for (int i = 0; i < 8; i++) tick();
    rd_beat_valid = 0; #1;
    tests++; if (miss_done !== 1'b1 || plru_access !== 4'b1000 || fill_way !== 2'd3) begin
      fails++; $display("FAIL b2b_done done=%b acc=%b way=%0d exp=1,1000,3", miss_done, plru_access, fill_way); end
    tick();
    lookup_valid = 1; hit_way = 4'b0001; #1;
    tests++; if (lookup_ready !== 1'b1 || plru_update !== 1'b1 || plru_access !== 4'b0001 || miss_done !== 1'b0) begin
      fails++; $display("FAIL b2b_hit ready=%b upd=%b acc=%b done=%b exp=1,1,0001,0",
                        lookup_ready, plru_update, plru_access, miss_done); end
    tick(); lookup_valid = 0; hit_way = 0; #1;
    tests++; if (lookup_ready !== 1'b1 || rd_req !== 1'b0) begin
      fails++; $display("FAIL b2b_idle ready=%b rd=%b exp=1,0", lookup_ready, rd_req); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss();
    test_beat_gaps();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
